// File: rtl/window_feeder_15_pkg.sv
// Shared constants and types for the 15-tap window feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package window_feeder_15_pkg;

   localparam int WIN_LEN  = 15;
   localparam int SAMPLE_W = 8;
   localparam int WIN_W    = WIN_LEN * SAMPLE_W;
   localparam int CNT_W    = 4;

   // Window packing: slot 0 (oldest) in the low byte, slot 14 (newest) on top.
   localparam int OLDEST_LSB = 0;
   localparam int NEWEST_LSB = (WIN_LEN - 1) * SAMPLE_W;

   localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(WIN_LEN);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      STEP = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/window_feeder_15_valid_delay_line.sv
// Fixed-latency delay line for 1-bit strobes; each input pulse reappears alone.
// Latency: DEPTH clock edges from din to dout.
// Backpressure: none; free-running, async active-low clear drops pending pulses.
module valid_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   // Shift strobes one stage per edge; overlapping pulses stay independent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/window_feeder_15.sv
// Sliding 15-sample window feeder with stride and a fixed-latency result strobe.
// Latency: window valid the cycle after the completing sample; res_valid NODE_LAT edges after handshake.
// Backpressure: s_ready drops while a window is held; optional FEEDER_ZERO_PAD_EN preloads 7 zero taps.
module window_feeder_15
   import window_feeder_15_pkg::*;
#(
   parameter int STRIDE   = 1,
   parameter int NODE_LAT = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_start,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [WIN_W-1:0]    win_data,
   output logic                res_valid
);

`ifdef FEEDER_ZERO_PAD_EN
   // Seven zero taps already "present" so the first window is causally centred.
   localparam logic [CNT_W-1:0] FILL_INIT = CNT_W'(7);
`else
   localparam logic [CNT_W-1:0] FILL_INIT = '0;
`endif

   localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   fill_q, fill_d;
   logic [CNT_W-1:0]   stride_q, stride_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               xfer;
   logic               hs;
   logic               launch;

   // Handshake qualifiers are all derived from registered state, so win_ready
   // never reaches s_ready combinationally.
   assign s_ready   = (state_q != HOLD);
   assign win_valid = (state_q == HOLD);
   assign win_data  = win_q;
   assign xfer      = s_valid & s_ready;
   assign hs        = win_valid & win_ready;
   // A handshake coinciding with frame_start is overridden and launches nothing.
   assign launch    = hs & ~frame_start;

   // Next-state, counters and window shift; frame_start overrides everything.
   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      stride_d = stride_q;
      win_d    = win_q;
      if (frame_start) begin
         state_d  = FILL;
         fill_d   = FILL_INIT;
         stride_d = '0;
         win_d    = '0;
      end else begin
         if (xfer) begin
            win_d = {s_data, win_q[WIN_W-1:SAMPLE_W]};
         end
         case (state_q)
            FILL: begin
               if (xfer) begin
                  if (fill_q >= FILL_FULL - CNT_W'(1)) begin
                     fill_d  = FILL_FULL;
                     state_d = HOLD;
                  end else begin
                     fill_d = fill_q + CNT_W'(1);
                  end
               end
            end
            STEP: begin
               if (xfer) begin
                  if (stride_q >= STRIDE_C - CNT_W'(1)) begin
                     stride_d = STRIDE_C;
                     state_d  = HOLD;
                  end else begin
                     stride_d = stride_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (hs) begin
                  stride_d = '0;
                  state_d  = STEP;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // State, counters and window storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FILL;
         fill_q   <= FILL_INIT;
         stride_q <= '0;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         stride_q <= stride_d;
         win_q    <= win_d;
      end
   end

   valid_delay_line #(
      .DEPTH (NODE_LAT)
   ) u_res_dly (
      .clk   (clk),
      .reset (reset),
      .din   (launch),
      .dout  (res_valid)
   );

endmodule

// File: tb/tb_window_feeder_15.sv
// Directed bench for window_feeder_15: vector table plus hand-written corner sequences.
// Two instances: STRIDE=1 (a) and STRIDE=4 (b), both NODE_LAT=3.
// Optional FEEDER_ZERO_PAD_EN build runs the zero-pad sequence instead of the fill-from-empty ones.
module tb_window_feeder_15;

   logic         clk = 1'b0;
   logic         reset = 1'b0;

   logic         fs_a = 1'b0, sv_a = 1'b0, wr_a = 1'b0;
   logic [7:0]   sd_a = '0;
   logic         s_ready_a, win_valid_a, res_valid_a;
   logic [119:0] win_data_a;

   logic         fs_b = 1'b0, sv_b = 1'b0, wr_b = 1'b0;
   logic [7:0]   sd_b = '0;
   logic         s_ready_b, win_valid_b, res_valid_b;
   logic [119:0] win_data_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   window_feeder_15 #(.STRIDE(1), .NODE_LAT(3)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .frame_start (fs_a),
      .s_valid     (sv_a),
      .s_ready     (s_ready_a),
      .s_data      (sd_a),
      .win_valid   (win_valid_a),
      .win_ready   (wr_a),
      .win_data    (win_data_a),
      .res_valid   (res_valid_a)
   );

   window_feeder_15 #(.STRIDE(4), .NODE_LAT(3)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .frame_start (fs_b),
      .s_valid     (sv_b),
      .s_ready     (s_ready_b),
      .s_data      (sd_b),
      .win_valid   (win_valid_b),
      .win_ready   (wr_b),
      .win_data    (win_data_b),
      .res_valid   (res_valid_b)
   );

   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       wr;
      logic       fs;
      logic       e_srdy;
      logic       e_wv;
      logic       e_rv;
      logic       chk_dat;
      logic [7:0] e_a0;
      logic [7:0] e_a14;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mkv(logic sv, logic [7:0] sd, logic wr, logic fs,
                                logic e_srdy, logic e_wv, logic e_rv,
                                logic chk_dat, logic [7:0] e_a0, logic [7:0] e_a14);
      vec_t v;
      v.sv = sv; v.sd = sd; v.wr = wr; v.fs = fs;
      v.e_srdy = e_srdy; v.e_wv = e_wv; v.e_rv = e_rv;
      v.chk_dat = chk_dat; v.e_a0 = e_a0; v.e_a14 = e_a14;
      return v;
   endfunction

   // Window of consecutive sample values first..first+14, oldest in slot 0.
   function automatic logic [119:0] mkwin(int first);
      logic [119:0] w;
      for (int i = 0; i < 15; i++) begin
         w[i*8 +: 8] = 8'(first + i);
      end
      return w;
   endfunction

   task automatic chk(string nm, logic [119:0] act, logic [119:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive dut_a inputs on the falling edge, then let outputs settle for checking.
   task automatic drive_a(logic sv, logic [7:0] sd, logic wr, logic fs);
      @(negedge clk);
      sv_a = sv; sd_a = sd; wr_a = wr; fs_a = fs;
      #1;
   endtask

   int           nxt;
   int           wins;
   logic [7:0]   ga0[3];
   logic [7:0]   ga14[3];

   initial begin
      // Reset and idle-state checks
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("rst s_ready_a", s_ready_a, 1'b1);
      chk("rst win_valid_a", win_valid_a, 1'b0);
      chk("rst res_valid_a", res_valid_a, 1'b0);
      chk("rst win_data_a", win_data_a, '0);
      chk("rst s_ready_b", s_ready_b, 1'b1);
      chk("rst win_valid_b", win_valid_b, 1'b0);

`ifdef FEEDER_ZERO_PAD_EN
      // Zero-pad build: samples -1..-8 give 7 leading zeros then the 8 samples.
      for (int k = 1; k <= 8; k++) begin
         drive_a(1'b1, 8'(-k), 1'b0, 1'b0);
         chk($sformatf("pad%0d s_ready", k), s_ready_a, 1'b1);
         chk($sformatf("pad%0d win_valid", k), win_valid_a, 1'b0);
      end
      drive_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pad win_valid", win_valid_a, 1'b1);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("pad slot%0d", i), win_data_a[i*8 +: 8],
             (i < 7) ? 8'h00 : 8'(6 - i));
      end
`else
      // Table: STRIDE=1, samples 1..15 with win_ready=1, then watch res_valid.
      for (int k = 0; k < 15; k++) begin
         tbl[k] = mkv(1'b1, 8'(k + 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      tbl[15] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd15);
      tbl[16] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tbl[17] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tbl[18] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      tbl[19] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 20; i++) begin
         drive_a(tbl[i].sv, tbl[i].sd, tbl[i].wr, tbl[i].fs);
         chk($sformatf("v%0d s_ready", i), s_ready_a, tbl[i].e_srdy);
         chk($sformatf("v%0d win_valid", i), win_valid_a, tbl[i].e_wv);
         chk($sformatf("v%0d res_valid", i), res_valid_a, tbl[i].e_rv);
         if (tbl[i].chk_dat) begin
            chk($sformatf("v%0d a0", i), win_data_a[7:0], tbl[i].e_a0);
            chk($sformatf("v%0d a14", i), win_data_a[119:112], tbl[i].e_a14);
         end
      end

      // Backpressure: window 2..16 held for 10 cycles with a sample waiting.
      drive_a(1'b1, 8'd16, 1'b0, 1'b0);
      chk("bp accept16", s_ready_a, 1'b1);
      for (int c = 0; c < 10; c++) begin
         drive_a(1'b1, 8'd17, 1'b0, 1'b0);
         chk($sformatf("bp%0d s_ready", c), s_ready_a, 1'b0);
         chk($sformatf("bp%0d win_valid", c), win_valid_a, 1'b1);
         chk($sformatf("bp%0d win_data", c), win_data_a, mkwin(2));
      end
      drive_a(1'b1, 8'd17, 1'b1, 1'b0);
      chk("bp release wv", win_valid_a, 1'b1);
      drive_a(1'b1, 8'd17, 1'b1, 1'b0);
      chk("bp accept17", s_ready_a, 1'b1);
      drive_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("bp next wv", win_valid_a, 1'b1);
      chk("bp next win", win_data_a, mkwin(3));

      // frame_start on the same cycle as the 15th sample drops it and restarts.
      drive_a(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 1; k <= 14; k++) begin
         drive_a(1'b1, 8'(k), 1'b0, 1'b0);
      end
      drive_a(1'b1, 8'd15, 1'b0, 1'b1);
      drive_a(1'b1, 8'd101, 1'b0, 1'b0);
      chk("fs no window", win_valid_a, 1'b0);
      chk("fs s_ready", s_ready_a, 1'b1);
      for (int k = 102; k <= 115; k++) begin
         drive_a(1'b1, 8'(k), 1'b0, 1'b0);
      end
      chk("fs 14 samples no window", win_valid_a, 1'b0);
      drive_a(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fs refill wv", win_valid_a, 1'b1);
      chk("fs refill win", win_data_a, mkwin(101));

      // STRIDE=4 on dut_b: samples 1..23 offered back to back.
      nxt  = 1;
      wins = 0;
      for (int c = 0; c < 200 && wins < 3; c++) begin
         @(negedge clk);
         sv_b = (nxt <= 23);
         sd_b = 8'(nxt);
         wr_b = 1'b1;
         #1;
         if (win_valid_b) begin
            ga0[wins]  = win_data_b[7:0];
            ga14[wins] = win_data_b[119:112];
            wins++;
         end else if (sv_b && s_ready_b) begin
            nxt++;
         end
      end
      @(negedge clk);
      sv_b = 1'b0;
      wr_b = 1'b0;
      chk("st4 window count", 32'(wins), 32'd3);
      chk("st4 w1 a0", ga0[0], 8'd1);
      chk("st4 w1 a14", ga14[0], 8'd15);
      chk("st4 w2 a0", ga0[1], 8'd5);
      chk("st4 w2 a14", ga14[1], 8'd19);
      chk("st4 w3 a0", ga0[2], 8'd9);
      chk("st4 w3 a14", ga14[2], 8'd23);
`endif

      // Reset one cycle after a handshake kills the pending res_valid.
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rst2 pre wv", win_valid_a, 1'b1);
      @(negedge clk);
      wr_a  = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst2 in wv", win_valid_a, 1'b0);
      chk("rst2 in rv", res_valid_a, 1'b0);
      chk("rst2 in win", win_data_a, '0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         drive_a(1'b0, 8'h00, 1'b0, 1'b0);
         chk($sformatf("rst2 c%0d res_valid", c), res_valid_a, 1'b0);
         chk($sformatf("rst2 c%0d win_valid", c), win_valid_a, 1'b0);
         chk($sformatf("rst2 c%0d s_ready", c), s_ready_a, 1'b1);
      end
      chk("rst2 win_data", win_data_a, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/window_feeder_15.md
WINDOW_FEEDER_15 -- requirements
Module: window_feeder_15

Interface
REQ-001 The block SHALL have parameter STRIDE, default 1, meaning new samples accepted between consecutive emitted windows (legal 1..15).
REQ-002 The block SHALL have parameter NODE_LAT, default 3, meaning clock edges from window acceptance to a valid downstream node output (legal 1..7).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port frame_start  input  1  single-cycle pulse that discards window contents and restarts filling.
REQ-006 The block SHALL have port s_valid  input  1  input sample valid.
REQ-007 The block SHALL have port s_ready  output  1  block can accept a sample this cycle.
REQ-008 The block SHALL have port s_data  input  8  signed sample.
REQ-009 The block SHALL have port win_valid  output  1  win_data holds a complete window.
REQ-010 The block SHALL have port win_ready  input  1  downstream accepts the window.
REQ-011 The block SHALL have port win_data  output  120  packed window; A0x at [7:0] is the oldest sample, A14x at [119:112] the newest.
REQ-012 The block SHALL have port res_valid  output  1  one-cycle strobe marking the node output produced by an accepted window.

Function
REQ-013 Sample transfer SHALL occur on a rising edge where s_valid and s_ready are both 1; the sample shifts into slot 14 and all slots shift one place toward slot 0.
REQ-014 The state machine SHALL have three states: FILL (fewer than 15 samples since start), STEP (stride counter below STRIDE) and HOLD (window presented, awaiting win_ready).
REQ-015 FILL SHALL go to HOLD on the transfer that brings the fill count to 15; STEP SHALL go to HOLD on the transfer that brings the stride counter to STRIDE; HOLD SHALL go to STEP with the stride counter cleared on a win_ready handshake.
REQ-016 win_valid SHALL be 1 only in HOLD; win_data SHALL remain unchanged while win_valid=1 and win_ready=0.
REQ-017 s_ready SHALL be 0 in HOLD and 1 in FILL and STEP, with no combinational path from win_ready to s_ready.
REQ-018 When win_valid and win_ready are both 1, res_valid SHALL pulse for exactly one cycle NODE_LAT edges later, independent of later handshakes; overlapping windows SHALL each produce their own pulse.
REQ-019 frame_start SHALL take priority over any same-cycle transfer or handshake: clear all slots, counters and state to FILL, and drop the in-flight sample; pending res_valid pulses SHALL still be delivered.
REQ-020 The fill counter SHALL saturate at 15 and the stride counter SHALL wrap to 0 on each handshake; neither SHALL overflow for any input sequence.
REQ-021 Samples SHALL pass unmodified, with no arithmetic and no width change.

Reset
REQ-022 When reset is low, state SHALL be FILL, all slots 0, counters 0, win_valid 0, res_valid 0 and the delay line cleared; s_ready SHALL be 1 from the first edge after reset deasserts.
REQ-023 Reset asserted mid-window or mid-delay SHALL discard all pending windows and res_valid pulses.

Configuration
REQ-024 With macro FEEDER_ZERO_PAD_EN defined, frame_start and reset SHALL preload the fill count to 7 with zero-valued slots, so the first window is emitted after 8 samples (7 leading zeros, causal "same" padding).
REQ-025 Without FEEDER_ZERO_PAD_EN, the first window SHALL require 15 real samples.

Structure
REQ-026 A shared package SHALL hold WIN_LEN=15, SAMPLE_W=8, the state enum type and the window packing constants.
REQ-027 The NODE_LAT delay SHALL be a sub-module named valid_delay_line (a parameterised shift register of 1-bit strobes with asynchronous active-low clear).

Verification
REQ-028 Bench: STRIDE=1, samples 1..15 streamed with win_ready=1 -> win_valid on the cycle after sample 15; A0x=1 and A14x=15; res_valid 3 cycles after the handshake.
REQ-029 Bench: STRIDE=4, samples 1..23 continuous -> second window A0x=5, A14x=19; third window A0x=9, A14x=23.
REQ-030 Bench: win_ready held 0 for 10 cycles while s_valid=1 -> s_ready=0 and win_data stable throughout; no sample lost after release.
REQ-031 Bench: frame_start in the same cycle as the 15th sample transfer -> no window emitted; the fill count restarts, and the next window contains only samples sent after frame_start.
REQ-032 Bench: FEEDER_ZERO_PAD_EN defined, samples -1..-8 -> first window A0x..A6x=0 and A7x=-1, A14x=-8 (0xF8).
REQ-033 Bench: reset pulled low 1 cycle after a handshake -> no res_valid pulse; all outputs 0 and s_ready=1 after release.
